// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared sizing, types and helpers for the down-sizing FIFO.
//   P_DEEPWID / P_RATIO / P_BITWID : default geometry (the FIFO parameters
//                                    must agree with these, since ptr_t and
//                                    cnt_t are sized from them)
//   DEEP                           : depth in narrow words
//   ptr_t                          : narrow-word address, wraps modulo DEEP
//   cnt_t                          : occupancy count, 0..DEEP
//   lane_addr(ptr, k)              : narrow address of lane k of a write at ptr
package sfifo_pkg;

    localparam int P_DEEPWID = 3;
    localparam int P_RATIO   = 2;
    localparam int P_BITWID  = 5;
    localparam int DEEP      = 2 ** P_DEEPWID;

    typedef logic [P_DEEPWID-1:0] ptr_t;
    typedef logic [P_DEEPWID:0]   cnt_t;

    function automatic ptr_t lane_addr(ptr_t ptr, int unsigned k);
        return ptr + ptr_t'(k);
    endfunction

endpackage

// File: rtl/sfifo_bank_ram.sv
// sfifo_bank_ram: RATIO banks of DEEP/RATIO rows x BITWID.
// Narrow address a lives in bank a%RATIO, row a/RATIO, so one aligned wide
// write fills a single row across every bank, and a narrow read picks one
// bank through the registered output mux.
//   clk, rd_rst_n : clock, async active-high reset (clears contents and rdat)
//   we, waddr     : write strobe, RATIO-aligned narrow address
//   wdat          : packed lanes, lane 0 in the low bits
//   re, raddr     : read strobe, narrow address
//   rdat          : registered read data, held when re is low
module sfifo_bank_ram
    import sfifo_pkg::*;
#(
    parameter int DEEPWID = P_DEEPWID,
    parameter int RATIO   = P_RATIO,
    parameter int BITWID  = P_BITWID
) (
    input  logic                     clk,
    input  logic                     rd_rst_n,
    input  logic                     we,
    input  logic [DEEPWID-1:0]       waddr,
    input  logic [BITWID*RATIO-1:0]  wdat,
    input  logic                     re,
    input  logic [DEEPWID-1:0]       raddr,
    output logic [BITWID-1:0]        rdat
);

    localparam int DEPTH = 2 ** DEEPWID;
    localparam int ROWS  = DEPTH / RATIO;
    // Index widths are kept at least one bit so RATIO==1 or RATIO==DEPTH
    // still elaborate; any extra row/bank is simply never addressed.
    localparam int RW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [BITWID-1:0] mem_q [2**BW][2**RW];
    logic [BITWID-1:0] rdat_q;
    logic [RW-1:0]     rrow;
    logic [BW-1:0]     rbank;

    always_comb begin
        rrow  = RW'(int'(raddr) / RATIO);
        rbank = BW'(int'(raddr) % RATIO);
    end

    always_ff @(posedge clk or posedge rd_rst_n) begin
        if (rd_rst_n) begin
            for (int b = 0; b < 2**BW; b++) begin
                for (int r = 0; r < 2**RW; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
            rdat_q <= '0;
        end else begin
            if (we) begin
                for (int k = 0; k < RATIO; k++) begin
                    mem_q[BW'(k)][RW'(int'(lane_addr(waddr, k)) / RATIO)] <= wdat[k*BITWID +: BITWID];
                end
            end
            if (re) begin
                rdat_q <= mem_q[rbank][rrow];
            end
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/sfifo_dwc.sv
// sfifo_dwc: single-clock FIFO that accepts RATIO narrow words per write and
// returns one narrow word per read.
//   clk, rd_rst_n                : clock, async active-high reset
//   wr, wr_dat                   : write request, packed lanes (lane 0 read first)
//   rd, rd_dat, rd_dat_vld       : read request, registered data, 1-cycle strobe
//   cfg_almost_full/_empty       : thresholds, sampled every cycle
//   full, empty, almost_full,
//   almost_empty, num            : registered status derived from next count
//   ovf, udf                     : sticky rejected-write / rejected-read flags
module sfifo_dwc
    import sfifo_pkg::*;
#(
    parameter int DEEPWID = P_DEEPWID,
    parameter int RATIO   = P_RATIO,
    parameter int BITWID  = P_BITWID
) (
    input  logic                     clk,
    input  logic                     rd_rst_n,
    input  logic                     wr,
    input  logic [BITWID*RATIO-1:0]  wr_dat,
    input  logic                     rd,
    output logic [BITWID-1:0]        rd_dat,
    output logic                     rd_dat_vld,
    input  logic [DEEPWID:0]         cfg_almost_full,
    input  logic [DEEPWID:0]         cfg_almost_empty,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [DEEPWID:0]         num,
    output logic                     ovf,
    output logic                     udf
);

    localparam int NW = DEEPWID + 2;
    typedef logic [NW-1:0] wide_t;

    ptr_t  wptr_q, wptr_d;
    ptr_t  rptr_q, rptr_d;
    cnt_t  num_q, num_d;
    wide_t num_wide;
    logic  wacc, racc;
    logic  full_q, full_d;
    logic  empty_q, empty_d;
    logic  af_q, af_d;
    logic  ae_q, ae_d;
    logic  ovf_q, ovf_d;
    logic  udf_q, udf_d;
    logic  vld_q;

    // Accept decisions look only at registered flags, so a same-cycle read
    // never makes room for a write and a same-cycle write never feeds a read.
    always_comb begin
        wacc     = wr & ~full_q;
        racc     = rd & ~empty_q;
        num_wide = {1'b0, num_q}
                 + (wacc ? wide_t'(RATIO) : '0)
                 - (racc ? wide_t'(1) : '0);
        num_d    = num_wide[DEEPWID:0];
        wptr_d   = wacc ? wptr_q + ptr_t'(RATIO) : wptr_q;
        rptr_d   = racc ? rptr_q + ptr_t'(1) : rptr_q;
        full_d   = (wide_t'(DEEP) - num_wide) < wide_t'(RATIO);
        empty_d  = (num_d == '0);
        af_d     = (num_d >= cfg_almost_full);
        ae_d     = (num_d <= cfg_almost_empty);
        ovf_d    = ovf_q | (wr & full_q);
        udf_d    = udf_q | (rd & empty_q);
    end

    always_ff @(posedge clk or posedge rd_rst_n) begin
        if (rd_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            num_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            // Count is zero in reset, so the flag tracks the live threshold.
            af_q    <= (cfg_almost_full == '0);
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            num_q   <= num_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            vld_q   <= racc;
        end
    end

    sfifo_bank_ram #(
        .DEEPWID (DEEPWID),
        .RATIO   (RATIO),
        .BITWID  (BITWID)
    ) u_ram (
        .clk      (clk),
        .rd_rst_n (rd_rst_n),
        .we       (wacc),
        .waddr    (wptr_q),
        .wdat     (wr_dat),
        .re       (racc),
        .raddr    (rptr_q),
        .rdat     (rd_dat)
    );

    assign rd_dat_vld   = vld_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign num          = num_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

endmodule

// File: tb/tb_sfifo_dwc.sv
module tb_sfifo_dwc;

    localparam int DW   = 3;
    localparam int R    = 2;
    localparam int BW   = 5;
    localparam int DEEP = 2 ** DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [R*BW-1:0] wr_dat = '0;
    logic [BW-1:0] rd_dat;
    logic          vld;
    logic [DW:0]   cfg_af = 4'd6;
    logic [DW:0]   cfg_ae = 4'd2;
    logic          full, empty, af, ae, ovf, udf;
    logic [DW:0]   num;

    always #5 clk = ~clk;

    sfifo_dwc #(.DEEPWID(DW), .RATIO(R), .BITWID(BW)) dut (
        .clk              (clk),
        .rd_rst_n         (rst),
        .wr               (wr),
        .wr_dat           (wr_dat),
        .rd               (rd),
        .rd_dat           (rd_dat),
        .rd_dat_vld       (vld),
        .cfg_almost_full  (cfg_af),
        .cfg_almost_empty (cfg_ae),
        .full             (full),
        .empty            (empty),
        .almost_full      (af),
        .almost_empty     (ae),
        .num              (num),
        .ovf              (ovf),
        .udf              (udf)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO contents as a plain queue of narrow words.
    logic [BW-1:0] model_q[$];
    logic [BW-1:0] exp_q[$];
    bit ovf_m = 0, udf_m = 0, vld_m = 0;
    int reads_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = model_q.size();
        chk("num", 32'(num), sz);
        chk("full", 32'(full), 32'((DEEP - sz) < R));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(af), 32'(sz >= int'(cfg_af)));
        chk("almost_empty", 32'(ae), 32'(sz <= int'(cfg_ae)));
        chk("ovf", 32'(ovf), 32'(ovf_m));
        chk("udf", 32'(udf), 32'(udf_m));
        chk("rd_dat_vld", 32'(vld), 32'(vld_m));
    endtask

    // Drive one cycle of requests, advance the model, then check status.
    task automatic cycle(input bit w, input bit r, input logic [R*BW-1:0] d);
        bit wacc, racc;
        wr = w; rd = r; wr_dat = d;
        wacc = w && ((DEEP - model_q.size()) >= R);
        racc = r && (model_q.size() > 0);
        if (w && !wacc) ovf_m = 1;
        if (r && !racc) udf_m = 1;
        if (racc) begin
            exp_q.push_back(model_q.pop_front());
            reads_done++;
        end
        if (wacc) for (int k = 0; k < R; k++) model_q.push_back(d[k*BW +: BW]);
        vld_m = racc;
        @(posedge clk); #2;
        check_status();
        wr = 0; rd = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_dat"}, 32'(rd_dat), 0);
        chk({tag, "_vld"}, 32'(vld), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_af"}, 32'(af), 32'(cfg_af == 0));
        chk({tag, "_ae"}, 32'(ae), 1);
        chk({tag, "_num"}, 32'(num), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_udf"}, 32'(udf), 0);
    endtask

    // Called at posedge+2; asserts reset mid-cycle, checks immediately.
    task automatic do_reset(input string tag);
        #1;
        rst = 1; wr = 1; rd = 1;
        #1;
        model_q.delete(); exp_q.delete();
        ovf_m = 0; udf_m = 0; vld_m = 0;
        check_reset_values(tag);
        repeat (3) @(posedge clk);
        #2;
        check_reset_values({tag, "_held"});
        rst = 0; wr = 0; rd = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes read data.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst && vld) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_dat_unexpected: got %0h with vld, want no data at %0t", rd_dat, $time);
                end else begin
                    chk("rd_dat", 32'(rd_dat), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int cyc;
        rst = 1;
        repeat (3) @(posedge clk);
        #2;
        rst = 0;
        check_reset_values("reset");

        // Lane order
        cycle(1, 0, 10'h3E1);
        chk("lane_num", 32'(num), 2);
        cycle(0, 1, '0);
        chk("lane0", 32'(rd_dat), 32'h01);
        cycle(0, 1, '0);
        chk("lane1", 32'(rd_dat), 32'h1F);

        // Fill to full, then an overflowing write
        for (int i = 0; i < 4; i++) cycle(1, 0, 10'($urandom()));
        chk("fill_full", 32'(full), 1);
        chk("fill_af", 32'(af), 1);
        cycle(1, 0, 10'($urandom()));
        chk("fill_ovf", 32'(ovf), 1);
        chk("fill_num", 32'(num), 8);

        // Partial full at 7, then simultaneous wr+rd
        cycle(0, 1, '0);
        chk("pf_full7", 32'(full), 1);
        cycle(1, 1, 10'($urandom()));
        chk("pf_num", 32'(num), 6);
        chk("pf_full", 32'(full), 0);

        // Drain, underflow, simultaneous wr+rd at empty
        for (int i = 0; i < 6; i++) cycle(0, 1, '0);
        cycle(0, 1, '0);
        chk("empty_udf", 32'(udf), 1);
        chk("empty_vld", 32'(vld), 0);
        cycle(1, 1, 10'($urandom()));
        chk("empty_wrrd_num", 32'(num), 2);
        chk("empty_wrrd_vld", 32'(vld), 0);

        // Random soak with moving thresholds
        do_reset("soak_rst");
        reads_done = 0;
        cyc = 0;
        while (reads_done < 10000 && cyc < 60000) begin
            cfg_af = 4'($urandom_range(0, DEEP));
            cfg_ae = 4'($urandom_range(0, DEEP));
            cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 75, 10'($urandom()));
            cyc++;
        end
        chk("soak_reads_reached", 32'(reads_done >= 10000), 1);
        cfg_af = 4'd6;
        cfg_ae = 4'd2;

        // Mid-stream reset
        for (int i = 0; i < 20; i++) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 10'($urandom()));
        do_reset("mid_rst");
        cycle(0, 0, '0);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
